sp_mem_arbiter: RTL and testbench

- Shares one single-ported synchronous RAM (one access per cycle, 1-cycle read latency, write-first read-during-write) between two requesters, e.g. the SHA3 absorb/squeeze engine (port 0) and the ROLLO encrypt datapath (port 1).
- Round-robin arbitration with per-port lock for uninterrupted bursts; returns read data tagged to the issuing port.

---
 rtl/sp_mem_arbiter.sv | 118 +++++++++++
 tb/tb_sp_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sp_mem_arbiter.sv
// sp_mem_arbiter
// Shares one single-ported synchronous RAM (1-cycle read latency) between
// two requesters. Contention is resolved round-robin; a requester can hold
// ownership across a burst with its lock input. Read data from the RAM is
// passed straight through on rdata and tagged to the issuing port by
// rvalid0/rvalid1, which rise exactly one cycle after an accepted read.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   reqN, weN, lockN       request, write(1)/read(0), keep ownership after access
//   addrN, wdataN          word address and write data of port N
//   gntN                   access accepted this cycle (combinational)
//   rvalidN                rdata belongs to port N (registered)
//   rdata                  shared read data (pass-through of mem_do)
//   mem_en/we/addr/di      RAM drive
//   mem_do                 RAM read data, valid the cycle after mem_en
module sp_mem_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic                     lock0,
    input  logic                     lock1,
    input  logic [$clog2(DEPTH)-1:0] addr0,
    input  logic [$clog2(DEPTH)-1:0] addr1,
    input  logic [WIDTH-1:0]         wdata0,
    input  logic [WIDTH-1:0]         wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [WIDTH-1:0]         rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [WIDTH-1:0]         mem_di,
    input  logic [WIDTH-1:0]         mem_do
);

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_reg;
    logic   lw_reg;        // last winner: contention goes to the other port
    logic   rvalid0_reg;
    logic   rvalid1_reg;

    // Grant decode. Gated by rst_n so nothing reaches the RAM while reset
    // is asserted, even though requesters may still be driving req.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            case (state_reg)
                FREE: begin
                    if (req0 && req1) begin
                        gnt0 = lw_reg;
                        gnt1 = ~lw_reg;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                // The owner keeps the RAM even while idle; the other port waits.
                OWN0:    gnt0 = req0;
                OWN1:    gnt1 = req1;
                default: ;
            endcase
        end
    end

    // RAM drive follows the winner; port 0 fields are the idle default.
    always_comb begin
        mem_en   = gnt0 | gnt1;
        mem_we   = gnt1 ? we1 : (gnt0 & we0);
        mem_addr = gnt1 ? addr1 : addr0;
        mem_di   = gnt1 ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= FREE;
            lw_reg      <= 1'b1;
            rvalid0_reg <= 1'b0;
            rvalid1_reg <= 1'b0;
        end else begin
            rvalid0_reg <= gnt0 & ~we0;
            rvalid1_reg <= gnt1 & ~we1;
            if (gnt0) begin
                lw_reg    <= 1'b0;
                state_reg <= lock0 ? OWN0 : FREE;
            end else if (gnt1) begin
                lw_reg    <= 1'b1;
                state_reg <= lock1 ? OWN1 : FREE;
            end else begin
                // Idle owner releases only when it drops its lock.
                case (state_reg)
                    OWN0:    if (!req0 && !lock0) state_reg <= FREE;
                    OWN1:    if (!req1 && !lock1) state_reg <= FREE;
                    default: ;
                endcase
            end
        end
    end

    assign rvalid0 = rvalid0_reg;
    assign rvalid1 = rvalid1_reg;
    assign rdata   = mem_do;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
module tb_sp_mem_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic             clk;
    logic             rst_n;
    logic             req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0]    addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic             gnt0, gnt1, rvalid0, rvalid1;
    logic [WIDTH-1:0] rdata;
    logic             mem_en, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_di;
    logic [WIDTH-1:0] mem_do;

    int checks   = 0;
    int failures = 0;

    sp_mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
        .mem_do(mem_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, write-first, preloaded with 0x40 + addr.
    logic [WIDTH-1:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'(8'h40 + i);
        mem_do = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_di;
                mem_do        <= mem_di;
            end else begin
                mem_do <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             r0, r1, w0, w1, l0, l1;
        logic [AW-1:0]    a0, a1;
        logic [WIDTH-1:0] d0, d1;
        logic             eg0, eg1, ev0, ev1;
        logic [WIDTH-1:0] erd;
    } vec_t;

    function automatic vec_t v(input int r0, r1, w0, w1, l0, l1, a0, a1, d0, d1,
                               input int eg0, eg1, ev0, ev1, erd);
        vec_t x;
        x.r0 = 1'(r0);  x.r1 = 1'(r1);  x.w0 = 1'(w0);  x.w1 = 1'(w1);
        x.l0 = 1'(l0);  x.l1 = 1'(l1);
        x.a0 = AW'(a0); x.a1 = AW'(a1);
        x.d0 = 8'(d0);  x.d1 = 8'(d1);
        x.eg0 = 1'(eg0); x.eg1 = 1'(eg1); x.ev0 = 1'(ev0); x.ev1 = 1'(ev1);
        x.erd = 8'(erd);
        return x;
    endfunction

    localparam int NV = 22;
    vec_t vecs [NV];

    // Expected RAM content for the single-requester sweep (addr 7 was rewritten).
    function automatic logic [31:0] ram_exp(input int a);
        return (a == 7) ? 32'hA5 : 32'(8'h40 + a);
    endfunction

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    initial begin
        //          r0 r1 w0 w1 l0 l1 a0 a1  d0 d1    eg0 eg1 ev0 ev1 erd
        // alternating contention after reset (port 0 first)
        vecs[0]  = v(1, 1, 0, 0, 0, 0, 3, 5,  0, 0,     1, 0, 0, 0, 'h00);
        vecs[1]  = v(1, 1, 0, 0, 0, 0, 3, 5,  0, 0,     0, 1, 1, 0, 'h43);
        vecs[2]  = v(1, 1, 0, 0, 0, 0, 3, 5,  0, 0,     1, 0, 0, 1, 'h45);
        vecs[3]  = v(1, 1, 0, 0, 0, 0, 3, 5,  0, 0,     0, 1, 1, 0, 'h43);
        vecs[4]  = v(0, 0, 0, 0, 0, 0, 0, 0,  0, 0,     0, 0, 0, 1, 'h45);
        // port 1 writes 0xA5 @7, port 0 reads it back
        vecs[5]  = v(0, 1, 0, 1, 0, 0, 0, 7,  0, 'hA5,  0, 1, 0, 0, 'h00);
        vecs[6]  = v(1, 0, 0, 0, 0, 0, 7, 0,  0, 0,     1, 0, 0, 0, 'h00);
        vecs[7]  = v(0, 0, 0, 0, 0, 0, 0, 0,  0, 0,     0, 0, 1, 0, 'hA5);
        // port 1 read sets lw=1, then port 0 locked 4-beat burst vs req1
        vecs[8]  = v(0, 1, 0, 0, 0, 0, 0, 8,  0, 0,     0, 1, 0, 0, 'h00);
        vecs[9]  = v(1, 1, 0, 0, 1, 0, 0, 9,  0, 0,     1, 0, 0, 1, 'h48);
        vecs[10] = v(1, 1, 0, 0, 1, 0, 1, 9,  0, 0,     1, 0, 1, 0, 'h40);
        vecs[11] = v(1, 1, 0, 0, 1, 0, 2, 9,  0, 0,     1, 0, 1, 0, 'h41);
        vecs[12] = v(1, 1, 0, 0, 0, 0, 3, 9,  0, 0,     1, 0, 1, 0, 'h42);
        vecs[13] = v(0, 1, 0, 0, 0, 0, 0, 9,  0, 0,     0, 1, 1, 0, 'h43);
        vecs[14] = v(0, 0, 0, 0, 0, 0, 0, 0,  0, 0,     0, 0, 0, 1, 'h49);
        // port 0 takes lock, idles 3 cycles holding it, then drops it
        vecs[15] = v(1, 1, 0, 0, 1, 0, 4, 10, 0, 0,     1, 0, 0, 0, 'h00);
        vecs[16] = v(0, 1, 0, 0, 1, 0, 4, 10, 0, 0,     0, 0, 1, 0, 'h44);
        vecs[17] = v(0, 1, 0, 0, 1, 0, 4, 10, 0, 0,     0, 0, 0, 0, 'h00);
        vecs[18] = v(0, 1, 0, 0, 1, 0, 4, 10, 0, 0,     0, 0, 0, 0, 'h00);
        vecs[19] = v(0, 1, 0, 0, 0, 0, 4, 10, 0, 0,     0, 0, 0, 0, 'h00);
        vecs[20] = v(0, 1, 0, 0, 0, 0, 4, 10, 0, 0,     0, 1, 0, 0, 'h00);
        vecs[21] = v(0, 0, 0, 0, 0, 0, 0, 0,  0, 0,     0, 0, 0, 1, 'h4A);

        // Reset: requests and a write present, nothing may reach the RAM.
        idle_inputs();
        rst_n = 0;
        req0 = 1; req1 = 1; we0 = 1;
        #1;
        chk("rst.gnt0", 32'(gnt0), 0);
        chk("rst.gnt1", 32'(gnt1), 0);
        chk("rst.mem_en", 32'(mem_en), 0);
        chk("rst.mem_we", 32'(mem_we), 0);
        chk("rst.rvalid0", 32'(rvalid0), 0);
        chk("rst.rvalid1", 32'(rvalid1), 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req0 = vecs[i].r0; req1 = vecs[i].r1; we0 = vecs[i].w0; we1 = vecs[i].w1;
            lock0 = vecs[i].l0; lock1 = vecs[i].l1; addr0 = vecs[i].a0; addr1 = vecs[i].a1;
            wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
            #1;
            $display("vec %0d: gnt=%b%b rvalid=%b%b rdata=%02h mem_en=%b", i,
                     gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en);
            chk($sformatf("v%0d.gnt0", i), 32'(gnt0), 32'(vecs[i].eg0));
            chk($sformatf("v%0d.gnt1", i), 32'(gnt1), 32'(vecs[i].eg1));
            chk($sformatf("v%0d.mem_en", i), 32'(mem_en), 32'(vecs[i].eg0 | vecs[i].eg1));
            chk($sformatf("v%0d.mem_we", i), 32'(mem_we),
                32'((vecs[i].eg0 & vecs[i].w0) | (vecs[i].eg1 & vecs[i].w1)));
            if (vecs[i].eg0) chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].a0));
            if (vecs[i].eg1) chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].a1));
            if (vecs[i].eg1 && vecs[i].w1) chk($sformatf("v%0d.mem_di", i), 32'(mem_di), 32'(vecs[i].d1));
            chk($sformatf("v%0d.rvalid0", i), 32'(rvalid0), 32'(vecs[i].ev0));
            chk($sformatf("v%0d.rvalid1", i), 32'(rvalid1), 32'(vecs[i].ev1));
            if (vecs[i].ev0 | vecs[i].ev1) chk($sformatf("v%0d.rdata", i), 32'(rdata), 32'(vecs[i].erd));
        end

        // Single requester: port 1 streams 10 reads, addr 0..9.
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            idle_inputs();
            if (i < 10) begin
                req1 = 1; addr1 = AW'(i);
            end
            #1;
            $display("stream %0d: gnt1=%b rvalid1=%b rdata=%02h", i, gnt1, rvalid1, rdata);
            if (i < 10) chk($sformatf("s%0d.gnt1", i), 32'(gnt1), 1);
            if (i > 0) begin
                chk($sformatf("s%0d.rvalid1", i), 32'(rvalid1), 1);
                chk($sformatf("s%0d.rvalid0", i), 32'(rvalid0), 0);
                chk($sformatf("s%0d.rdata", i), 32'(rdata), ram_exp(i - 1));
            end
        end

        // Reset during a locked read: rvalid drops at once, lock is dropped.
        @(negedge clk);
        idle_inputs();
        req0 = 1; addr0 = 2; lock0 = 1;
        #1 chk("r1.gnt0", 32'(gnt0), 1);
        @(negedge clk);
        req0 = 0; lock0 = 1; req1 = 1; addr1 = 6;
        #1;
        chk("r1.rvalid0", 32'(rvalid0), 1);
        chk("r1.rdata", 32'(rdata), 32'h42);
        chk("r1.blocked", 32'(gnt1), 0);
        #1 rst_n = 0;
        #1;
        $display("reset1: rvalid0=%b gnt1=%b mem_en=%b", rvalid0, gnt1, mem_en);
        chk("r1.rvalid0_async", 32'(rvalid0), 0);
        chk("r1.gnt1_in_rst", 32'(gnt1), 0);
        chk("r1.mem_en_in_rst", 32'(mem_en), 0);
        @(negedge clk);
        rst_n = 1; lock0 = 0;
        #1 chk("r1.lock_dropped", 32'(gnt1), 1);
        @(negedge clk);
        req1 = 0;
        #1;
        chk("r1.rvalid1", 32'(rvalid1), 1);
        chk("r1.rdata6", 32'(rdata), 32'h46);

        // Reset after port 0 won: first contention afterwards goes to port 0.
        @(negedge clk);
        req0 = 1; addr0 = 1;
        #1 chk("r2.gnt0", 32'(gnt0), 1);
        @(negedge clk);
        req0 = 0;
        #1 chk("r2.rvalid0", 32'(rvalid0), 1);
        #1 rst_n = 0;
        #1 chk("r2.rvalid0_async", 32'(rvalid0), 0);
        @(negedge clk);
        rst_n = 1;
        req0 = 1; req1 = 1; addr0 = 0; addr1 = 1;
        #1;
        $display("reset2: gnt=%b%b", gnt0, gnt1);
        chk("r2.first_gnt0", 32'(gnt0), 1);
        chk("r2.first_gnt1", 32'(gnt1), 0);
        @(negedge clk);
        req0 = 0;
        #1;
        chk("r2.next_gnt1", 32'(gnt1), 1);
        chk("r2.rvalid0b", 32'(rvalid0), 1);
        chk("r2.rdata0", 32'(rdata), 32'h40);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("r2.rvalid1", 32'(rvalid1), 1);
        chk("r2.rdata1", 32'(rdata), 32'h41);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
